icache_arb: RTL and testbench
=============================

ICACHE_ARB -- requirements
Module: icache_arb

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 2, maximum icache reads issued but not yet answered (legal range 1..4).
REQ-002 Parameter: STARVE_LIMIT, default 4, consecutive port-0 grants allowed while port 1 waits.
REQ-003 Parameter: STARVE_LIMIT is at least 1.
REQ-004 Ports: clk_i  in  1  the single clock, rising-edge.
REQ-005 Ports: rst_i  in  1  asynchronous, active-high reset.
REQ-006 Ports: req0_rd_i / req0_pc_i / req0_priv_i  in  1/32/2  fetch-unit read request, PC and privilege.
REQ-007 Ports: req0_flush_i / req0_invalidate_i  in  1/1  fetch-unit maintenance requests, held until accepted.
REQ-008 Ports: req0_accept_o  out  1  port-0 request or maintenance accepted this cycle.
REQ-009 Ports: req0_valid_o / req0_inst_o / req0_error_o / req0_page_fault_o  out  1/128/1/1  port-0 response.
REQ-010 Ports: req1_rd_i / req1_pc_i / req1_priv_i  in  1/32/2  prefetcher read request.
REQ-011 Ports: req1_accept_o  out  1  port-1 request accepted this cycle.
REQ-012 Ports: req1_valid_o / req1_inst_o / req1_error_o / req1_page_fault_o  out  1/128/1/1  port-1 response.
REQ-013 Ports: icache_rd_o / icache_flush_o / icache_invalidate_o / icache_pc_o / icache_priv_o  out  1/1/1/32/2  shared icache request.
REQ-014 Ports: icache_accept_i / icache_valid_i / icache_inst_i / icache_error_i / icache_page_fault_i  in  1/1/128/1/1  icache accept and response.

Function
REQ-015 Arbitration: port 0 wins over port 1 when both raise rd.
REQ-016 Starvation guard: when port 1 has waited and lost STARVE_LIMIT consecutive accepted grants to port 0, port 1 wins the next arbitration.
REQ-017 Starvation counter: clears on any port-1 accept or whenever req1_rd_i is low.
REQ-018 Issue: icache_rd_o is high only when a winner exists, no maintenance is pending, and outstanding count < MAX_OUTSTANDING.
REQ-019 Issue: icache_pc_o and icache_priv_o are driven from the winner.
REQ-020 Accept: reqN_accept_o = icache_accept_i AND icache_rd_o AND (winner==N), combinationally; the losing port sees accept low.
REQ-021 Owner FIFO: each accepted read pushes its owner ID into an in-order FIFO of depth MAX_OUTSTANDING.
REQ-022 Response routing: each icache_valid_i pops the FIFO head and drives reqN_valid_o, inst, error and page_fault to the head owner only, in the same cycle (zero latency); the other port's valid is low.
REQ-023 Same-cycle push/pop: count is unchanged and FIFO order is preserved.
REQ-024 Full FIFO: issue stalls.
REQ-025 Response with empty FIFO: the response is discarded, no valid is raised, and a sticky internal error flag is set for assertion checking.
REQ-026 Maintenance FSM states: IDLE, DRAIN, MAINT, WAIT_ACC.
REQ-027 IDLE: on req0_flush_i or req0_invalidate_i go to DRAIN; reads are blocked from this cycle.
REQ-028 DRAIN: when outstanding count==0 go to MAINT.
REQ-029 MAINT: assert icache_flush_o or icache_invalidate_o (flush wins if both are requested) together with icache_rd_o low, then go to WAIT_ACC.
REQ-030 WAIT_ACC: hold the strobe until icache_accept_i, pulse req0_accept_o for that cycle, then return to IDLE.
REQ-031 Maintenance accept: req0_accept_o for maintenance is never asserted in the same cycle as any read accept.
REQ-032 Request gaps: deasserting rd before accept is legal and creates no FIFO entry.
REQ-033 Request hold: a requester must hold pc/priv stable while rd is high and unaccepted; the arbiter does not switch winner away from a port whose request is still raised, except when the starvation guard fires on the next arbitration.

Reset
REQ-034 rst_i high immediately forces the FSM to IDLE, the FIFO to empty, the count and starvation counter to 0, and the error flag to 0.
REQ-035 During reset: all icache_* strobes, accepts and valids are 0; pc/priv outputs are 0.
REQ-036 Mid-operation reset: responses arriving for requests issued before reset are dropped, with no error flag set.

Verification
REQ-037 Both ports request every cycle with icache_accept_i=1 and STARVE_LIMIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1.
REQ-038 MAX_OUTSTANDING=2: port 0 issues A, port 1 issues B, no responses -> third request stalls (icache_rd_o=0); two responses -> req0_valid_o then req1_valid_o, each with matching inst data.
REQ-039 Two reads outstanding, req0_flush_i raised -> icache_flush_o stays 0 until both responses are returned, rises the next cycle, and req0_accept_o pulses only when icache_accept_i=1.
REQ-040 Push and pop in the same cycle with the FIFO full -> count stays 2, the new request is accepted, and order is preserved.
REQ-041 icache_valid_i with FIFO empty -> no reqN_valid_o, error flag=1.
REQ-042 Reset asserted with 1 outstanding, then response arrives after reset -> dropped, FIFO empty, outputs 0.

Source files
------------

// File: rtl/icache_arb.sv
// Two-port instruction-cache arbiter: fixed priority with a starvation guard, in-order
// response routing through an owner FIFO, and a drain-then-strobe maintenance sequencer.
module icache_arb #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         req0_rd_i,
   input  logic [31:0]  req0_pc_i,
   input  logic [1:0]   req0_priv_i,
   input  logic         req0_flush_i,
   input  logic         req0_invalidate_i,
   output logic         req0_accept_o,
   output logic         req0_valid_o,
   output logic [127:0] req0_inst_o,
   output logic         req0_error_o,
   output logic         req0_page_fault_o,
   input  logic         req1_rd_i,
   input  logic [31:0]  req1_pc_i,
   input  logic [1:0]   req1_priv_i,
   output logic         req1_accept_o,
   output logic         req1_valid_o,
   output logic [127:0] req1_inst_o,
   output logic         req1_error_o,
   output logic         req1_page_fault_o,
   output logic         icache_rd_o,
   output logic         icache_flush_o,
   output logic         icache_invalidate_o,
   output logic [31:0]  icache_pc_o,
   output logic [1:0]   icache_priv_o,
   input  logic         icache_accept_i,
   input  logic         icache_valid_i,
   input  logic [127:0] icache_inst_i,
   input  logic         icache_error_i,
   input  logic         icache_page_fault_i
);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [2:0]       MAX_CNT  = 3'(MAX_OUTSTANDING);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_MAINT, ST_WAIT_ACC} state_t;

   state_t               state_reg;
   logic                 maint_flush_reg;
   logic                 flush_strobe_reg;
   logic                 inval_strobe_reg;
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [2:0]           count_reg;
   logic [STV_W-1:0]     starve_reg;
   logic                 lock_valid_reg;
   logic                 lock_port_reg;
   logic                 err_flag_reg;
   logic                 drop_stale_reg;
   logic [MAX_OUTSTANDING-1:0] owner_vec;

   logic win_valid, win_port, starved, maint_block, pop, room;
   logic rd_issue, rd_acc, maint_acc, head_owner, drain_done;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // A raised-but-unaccepted winner keeps the grant; only the starvation guard overrides it.
   assign starved = req1_rd_i && (starve_reg >= STV_MAX);
   always_comb begin
      win_valid = 1'b0;
      win_port  = 1'b0;
      if (starved) begin
         win_valid = 1'b1;
         win_port  = 1'b1;
      end else if (lock_valid_reg && !lock_port_reg && req0_rd_i) begin
         win_valid = 1'b1;
      end else if (lock_valid_reg && lock_port_reg && req1_rd_i) begin
         win_valid = 1'b1;
         win_port  = 1'b1;
      end else if (req0_rd_i) begin
         win_valid = 1'b1;
      end else if (req1_rd_i) begin
         win_valid = 1'b1;
         win_port  = 1'b1;
      end
   end

   assign maint_block = (state_reg != ST_IDLE) || req0_flush_i || req0_invalidate_i;
   assign pop         = icache_valid_i && (count_reg != 3'd0);
   assign room        = (count_reg < MAX_CNT) || pop;
   assign rd_issue    = win_valid && !maint_block && room;
   assign rd_acc      = rd_issue && icache_accept_i;
   assign maint_acc   = ((state_reg == ST_MAINT) || (state_reg == ST_WAIT_ACC)) && icache_accept_i;
   assign head_owner  = owner_vec[rd_ptr_reg];
   assign drain_done  = (count_reg == 3'd0) || ((count_reg == 3'd1) && pop);

   genvar gi;
   generate
      for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot
         logic owner_reg;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)
               owner_reg <= 1'b0;
            else if (rd_acc && (wr_ptr_reg == PTR_W'(gi)))
               owner_reg <= win_port;
         end
         assign owner_vec[gi] = owner_reg;
      end
   endgenerate

   assign icache_rd_o         = !rst_i && rd_issue;
   assign icache_pc_o         = (!rst_i && win_valid) ? (win_port ? req1_pc_i : req0_pc_i) : '0;
   assign icache_priv_o       = (!rst_i && win_valid) ? (win_port ? req1_priv_i : req0_priv_i) : '0;
   assign icache_flush_o      = flush_strobe_reg;
   assign icache_invalidate_o = inval_strobe_reg;
   assign req0_accept_o       = !rst_i && ((rd_acc && !win_port) || maint_acc);
   assign req1_accept_o       = !rst_i && rd_acc && win_port;

   assign req0_valid_o      = !rst_i && pop && !head_owner;
   assign req1_valid_o      = !rst_i && pop && head_owner;
   assign req0_inst_o       = req0_valid_o ? icache_inst_i : '0;
   assign req1_inst_o       = req1_valid_o ? icache_inst_i : '0;
   assign req0_error_o      = req0_valid_o && icache_error_i;
   assign req1_error_o      = req1_valid_o && icache_error_i;
   assign req0_page_fault_o = req0_valid_o && icache_page_fault_i;
   assign req1_page_fault_o = req1_valid_o && icache_page_fault_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg        <= ST_IDLE;
         maint_flush_reg  <= 1'b0;
         flush_strobe_reg <= 1'b0;
         inval_strobe_reg <= 1'b0;
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         count_reg        <= '0;
         starve_reg       <= '0;
         lock_valid_reg   <= 1'b0;
         lock_port_reg    <= 1'b0;
         err_flag_reg     <= 1'b0;
         drop_stale_reg   <= 1'b1;
      end else begin
         if (rd_acc) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         case ({rd_acc, pop})
            2'b10:   count_reg <= count_reg + 3'd1;
            2'b01:   count_reg <= count_reg - 3'd1;
            default: count_reg <= count_reg;
         endcase

         // Responses to reads issued before a reset may still trickle in; swallow them
         // silently until the first post-reset read is accepted.
         if (rd_acc) drop_stale_reg <= 1'b0;
         if (icache_valid_i && (count_reg == 3'd0) && !drop_stale_reg) err_flag_reg <= 1'b1;

         if (!req1_rd_i || (rd_acc && win_port))
            starve_reg <= '0;
         else if (rd_acc && !win_port && (starve_reg != STV_MAX))
            starve_reg <= starve_reg + 1'b1;

         lock_valid_reg <= win_valid && !rd_acc;
         lock_port_reg  <= win_port;

         case (state_reg)
            ST_IDLE: begin
               if (req0_flush_i || req0_invalidate_i) begin
                  state_reg       <= ST_DRAIN;
                  maint_flush_reg <= req0_flush_i;
               end
            end
            ST_DRAIN: begin
               if (drain_done) begin
                  state_reg        <= ST_MAINT;
                  flush_strobe_reg <= maint_flush_reg;
                  inval_strobe_reg <= !maint_flush_reg;
               end
            end
            ST_MAINT, ST_WAIT_ACC: begin
               if (icache_accept_i) begin
                  state_reg        <= ST_IDLE;
                  flush_strobe_reg <= 1'b0;
                  inval_strobe_reg <= 1'b0;
               end else begin
                  state_reg <= ST_WAIT_ACC;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assert property (@(posedge clk_i) disable iff (rst_i) err_flag_reg |=> err_flag_reg);
   assert property (@(posedge clk_i) disable iff (rst_i) !(req0_valid_o && req1_valid_o));

endmodule

// File: tb/tb_icache_arb.sv
// Randomised bench for icache_arb with a rule-level reference model and directed scenarios.
module tb_icache_arb;
   localparam int MAXO = 2;
   localparam int SL   = 4;

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   logic         req0_rd_i = 1'b0, req1_rd_i = 1'b0;
   logic [31:0]  req0_pc_i = '0, req1_pc_i = '0;
   logic [1:0]   req0_priv_i = '0, req1_priv_i = '0;
   logic         req0_flush_i = 1'b0, req0_invalidate_i = 1'b0;
   logic         icache_accept_i = 1'b0, icache_valid_i = 1'b0;
   logic [127:0] icache_inst_i = '0;
   logic         icache_error_i = 1'b0, icache_page_fault_i = 1'b0;
   logic         req0_accept_o, req0_valid_o, req0_error_o, req0_page_fault_o;
   logic         req1_accept_o, req1_valid_o, req1_error_o, req1_page_fault_o;
   logic [127:0] req0_inst_o, req1_inst_o;
   logic         icache_rd_o, icache_flush_o, icache_invalidate_o;
   logic [31:0]  icache_pc_o;
   logic [1:0]   icache_priv_o;

   always #5 clk = ~clk;

   icache_arb #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req0_rd_i(req0_rd_i), .req0_pc_i(req0_pc_i), .req0_priv_i(req0_priv_i),
      .req0_flush_i(req0_flush_i), .req0_invalidate_i(req0_invalidate_i),
      .req0_accept_o(req0_accept_o), .req0_valid_o(req0_valid_o), .req0_inst_o(req0_inst_o),
      .req0_error_o(req0_error_o), .req0_page_fault_o(req0_page_fault_o),
      .req1_rd_i(req1_rd_i), .req1_pc_i(req1_pc_i), .req1_priv_i(req1_priv_i),
      .req1_accept_o(req1_accept_o), .req1_valid_o(req1_valid_o), .req1_inst_o(req1_inst_o),
      .req1_error_o(req1_error_o), .req1_page_fault_o(req1_page_fault_o),
      .icache_rd_o(icache_rd_o), .icache_flush_o(icache_flush_o),
      .icache_invalidate_o(icache_invalidate_o), .icache_pc_o(icache_pc_o),
      .icache_priv_o(icache_priv_o), .icache_accept_i(icache_accept_i),
      .icache_valid_i(icache_valid_i), .icache_inst_i(icache_inst_i),
      .icache_error_i(icache_error_i), .icache_page_fault_i(icache_page_fault_i)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owners of outstanding reads in issue order, plus rule state.
   bit mq[$];
   int grants[$];
   int m_starve = 0;
   int m_held = -1;
   bit m_pend = 0, m_strobe = 0, m_kflush = 0, m_err = 0, m_stale = 1;
   bit e_racc0 = 0, e_racc1 = 0, e_macc = 0;

   always @(negedge clk) begin : cmp
      int win;
      bit pop, room, blocked, rd, racc, macc, head, v0, v1;
      logic [31:0] epc;
      logic [1:0]  epriv;
      if (rst_i) begin
         chk("rst_rd", icache_rd_o, 0);
         chk("rst_strobes", {icache_flush_o, icache_invalidate_o}, 0);
         chk("rst_acc", {req0_accept_o, req1_accept_o}, 0);
         chk("rst_valid", {req0_valid_o, req1_valid_o}, 0);
         chk("rst_pcpriv", {icache_pc_o, icache_priv_o}, 0);
         chk("rst_err", dut.err_flag_reg, 0);
         mq.delete();
         m_starve = 0; m_held = -1; m_pend = 0; m_strobe = 0; m_err = 0; m_stale = 1;
         e_racc0 = 0; e_racc1 = 0; e_macc = 0;
      end else begin
         chk("err_flag", dut.err_flag_reg, m_err);
         win = -1;
         if (req1_rd_i && m_starve >= SL) win = 1;
         else if (m_held == 0 && req0_rd_i) win = 0;
         else if (m_held == 1 && req1_rd_i) win = 1;
         else if (req0_rd_i) win = 0;
         else if (req1_rd_i) win = 1;
         pop     = icache_valid_i && (mq.size() > 0);
         room    = (mq.size() < MAXO) || pop;
         blocked = m_pend || req0_flush_i || req0_invalidate_i;
         rd      = (win >= 0) && !blocked && room;
         racc    = rd && icache_accept_i;
         macc    = m_strobe && icache_accept_i;
         head    = pop ? mq[0] : 1'b0;
         v0      = pop && !head;
         v1      = pop && head;
         epc     = (win == 1) ? req1_pc_i : (win == 0) ? req0_pc_i : 32'h0;
         epriv   = (win == 1) ? req1_priv_i : (win == 0) ? req0_priv_i : 2'h0;
         chk("icache_rd", icache_rd_o, rd);
         chk("icache_pc", icache_pc_o, epc);
         chk("icache_priv", icache_priv_o, epriv);
         chk("icache_flush", icache_flush_o, m_strobe && m_kflush);
         chk("icache_inval", icache_invalidate_o, m_strobe && !m_kflush);
         chk("accept0", req0_accept_o, (racc && win == 0) || macc);
         chk("accept1", req1_accept_o, racc && win == 1);
         chk("valid0", req0_valid_o, v0);
         chk("valid1", req1_valid_o, v1);
         chk("inst0", req0_inst_o, v0 ? icache_inst_i : 128'h0);
         chk("inst1", req1_inst_o, v1 ? icache_inst_i : 128'h0);
         chk("errpf0", {req0_error_o, req0_page_fault_o}, v0 ? {icache_error_i, icache_page_fault_i} : 2'b00);
         chk("errpf1", {req1_error_o, req1_page_fault_o}, v1 ? {icache_error_i, icache_page_fault_i} : 2'b00);

         if (icache_valid_i && mq.size() == 0 && !m_stale) m_err = 1;
         if (pop) void'(mq.pop_front());
         if (racc) begin
            mq.push_back(win == 1);
            grants.push_back(win);
            m_stale = 0;
         end
         if (!req1_rd_i || (racc && win == 1)) m_starve = 0;
         else if (racc && win == 0) m_starve++;
         m_held = (win >= 0 && !racc) ? win : -1;
         if (m_strobe) begin
            if (macc) begin m_strobe = 0; m_pend = 0; end
         end else if (m_pend) begin
            if (mq.size() == 0) m_strobe = 1;
         end else if (req0_flush_i || req0_invalidate_i) begin
            m_pend = 1;
            m_kflush = req0_flush_i;
         end
         e_racc0 = racc && win == 0;
         e_racc1 = racc && win == 1;
         e_macc  = macc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      req0_rd_i = 0; req1_rd_i = 0; icache_accept_i = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         icache_valid_i = (mq.size() > 0);
      end
      tick();
      icache_valid_i = 0;
   endtask

   localparam logic [31:0] PC_A = 32'h1000_0000;
   localparam logic [31:0] PC_B = 32'h2000_0040;
   localparam logic [31:0] PC_C = 32'h3000_0080;

   initial begin
      int exp_g[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      int k;

      // Reset: a raised request must not reach the icache.
      req0_rd_i = 1; req0_pc_i = PC_A;
      @(negedge clk);
      chk("reset_rd_gated", icache_rd_o, 0);
      chk("reset_count", dut.count_reg, 0);
      tick();
      rst_i = 0; req0_rd_i = 0;
      tick();

      // Starvation guard with both ports always requesting.
      grants.delete();
      req0_rd_i = 1; req1_rd_i = 1; req0_pc_i = PC_A; req1_pc_i = PC_B; icache_accept_i = 1;
      for (int i = 0; i < 12; i++) begin
         icache_valid_i = (mq.size() > 0);
         icache_inst_i = {4{32'hCAFE_0000 + i}};
         tick();
      end
      chk("grant_count", grants.size() >= 10, 1);
      for (int i = 0; i < 10; i++) chk("grant_order", grants[i], exp_g[i]);
      drain();

      // Full FIFO stall, in-order routing and push+pop on a full FIFO.
      req0_rd_i = 1; req0_pc_i = PC_A; req1_rd_i = 1; req1_pc_i = PC_B; icache_accept_i = 1;
      @(negedge clk); chk("t38_acc_a", req0_accept_o, 1);
      tick(); req0_rd_i = 0;
      @(negedge clk); chk("t38_acc_b", req1_accept_o, 1);
      tick(); req1_rd_i = 0; req0_rd_i = 1; req0_pc_i = PC_C;
      @(negedge clk); chk("t38_stall", icache_rd_o, 0); chk("t38_stall_acc", req0_accept_o, 0);
      tick(); icache_valid_i = 1; icache_inst_i = {4{PC_A}};
      @(negedge clk);
      chk("t38_v0", req0_valid_o, 1); chk("t38_inst_a", req0_inst_o, {4{PC_A}});
      chk("t38_v1_low", req1_valid_o, 0); chk("t40_acc_c", req0_accept_o, 1);
      tick(); req0_rd_i = 0; icache_inst_i = {4{PC_B}};
      @(negedge clk);
      chk("t40_count", dut.count_reg, 2);
      chk("t38_v1", req1_valid_o, 1); chk("t38_inst_b", req1_inst_o, {4{PC_B}});
      tick(); icache_inst_i = {4{PC_C}};
      @(negedge clk); chk("t40_v0_c", req0_valid_o, 1); chk("t40_inst_c", req0_inst_o, {4{PC_C}});
      tick(); icache_valid_i = 0; icache_accept_i = 0;
      @(negedge clk); chk("t40_empty", dut.count_reg, 0);

      // Flush waits for the drain, then holds until accepted.
      tick(); req0_rd_i = 1; req0_pc_i = PC_A; icache_accept_i = 1;
      tick(); req0_pc_i = PC_B;
      tick(); req0_rd_i = 0; req0_flush_i = 1; icache_accept_i = 0;
      @(negedge clk); chk("t39_flush_wait0", icache_flush_o, 0);
      tick(); icache_valid_i = 1;
      @(negedge clk); chk("t39_flush_wait1", icache_flush_o, 0);
      tick();
      @(negedge clk); chk("t39_flush_wait2", icache_flush_o, 0);
      tick(); icache_valid_i = 0;
      @(negedge clk); chk("t39_flush_rise", icache_flush_o, 1); chk("t39_no_acc", req0_accept_o, 0);
      tick();
      @(negedge clk); chk("t39_flush_hold", icache_flush_o, 1); chk("t39_no_acc2", req0_accept_o, 0);
      tick(); icache_accept_i = 1;
      @(negedge clk); chk("t39_maint_acc", req0_accept_o, 1);
      tick(); req0_flush_i = 0; icache_accept_i = 0;
      @(negedge clk); chk("t39_flush_drop", icache_flush_o, 0);

      // Response with nothing outstanding.
      tick(); icache_valid_i = 1;
      @(negedge clk); chk("t41_no_valid", {req0_valid_o, req1_valid_o}, 0);
      tick(); icache_valid_i = 0;
      @(negedge clk); chk("t41_err_flag", dut.err_flag_reg, 1);

      // Reset with a read outstanding; its late response is dropped quietly.
      tick(); req0_rd_i = 1; req0_pc_i = PC_A; icache_accept_i = 1;
      tick(); req0_rd_i = 0; icache_accept_i = 0; rst_i = 1;
      @(negedge clk); chk("t42_count_rst", dut.count_reg, 0);
      tick(); rst_i = 0; icache_valid_i = 1; icache_inst_i = {4{PC_A}};
      @(negedge clk); chk("t42_dropped", {req0_valid_o, req1_valid_o}, 0);
      tick(); icache_valid_i = 0;
      @(negedge clk); chk("t42_no_err", dut.err_flag_reg, 0); chk("t42_empty", dut.count_reg, 0);

      // Randomised traffic.
      for (int i = 0; i < 4000; i++) begin
         tick();
         rst_i = ($urandom_range(0, 299) == 0);
         if (req0_flush_i || req0_invalidate_i) begin
            if (e_macc) begin req0_flush_i = 0; req0_invalidate_i = 0; end
         end else if ($urandom_range(0, 49) == 0) begin
            k = $urandom_range(1, 3);
            req0_flush_i = k[0]; req0_invalidate_i = k[1];
         end
         if (!(req0_rd_i && !e_racc0 && $urandom_range(0, 9) != 0)) begin
            req0_rd_i = ($urandom_range(0, 9) < 6);
            req0_pc_i = $urandom; req0_priv_i = 2'($urandom_range(0, 3));
         end
         if (!(req1_rd_i && !e_racc1 && $urandom_range(0, 9) != 0)) begin
            req1_rd_i = ($urandom_range(0, 9) < 5);
            req1_pc_i = $urandom; req1_priv_i = 2'($urandom_range(0, 3));
         end
         icache_accept_i = ($urandom_range(0, 9) < 7);
         icache_valid_i = (mq.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) == 0);
         icache_inst_i = {$urandom, $urandom, $urandom, $urandom};
         icache_error_i = ($urandom_range(0, 7) == 0);
         icache_page_fault_i = ($urandom_range(0, 7) == 0);
      end
      tick();
      rst_i = 0; req0_rd_i = 0; req1_rd_i = 0; icache_valid_i = 0; icache_accept_i = 0;
      req0_flush_i = 0; req0_invalidate_i = 0;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
